ttt_move_sequencer: RTL and testbench

Upstream front end for the tic_tac_toe game core. It accepts move requests from the player and computer sources over valid/ready handshakes and enforces strict turn alternation. It tracks the nine occupied cells and rejects illegal moves. Only validated moves are driven onto the core's play, player_pos and comp_pos inputs. It stops accepting moves when the core signals game over or the board is full.

---
 rtl/ttt_move_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_ttt_move_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_sequencer.sv
// ---------------------------------------------------------------------------
// ttt_move_sequencer
//
// Front end for the tic_tac_toe game core. Player and computer move requests
// arrive on two valid/ready channels. This block enforces strict turn
// alternation and tracks the nine occupied cells. Only legal moves are passed
// to the core through play / player_pos / comp_pos. The block stops taking
// moves once the core reports game_over or all nine cells are taken.
//
// Optional feature macro: TTT_TURN_TIMEOUT_EN
//   When this macro is defined, a side that does not make a legal move within
//   TIMEOUT_CYC cycles forfeits its turn, and the turn passes to the other
//   side. When it is undefined, turns wait indefinitely and timeout stays 0.
//
// Parameters
//   POS_W        width of the position buses (legal cells are 1..9)
//   FIRST_MOVER  side that moves first after start: 0 = player, 1 = computer
//   TIMEOUT_CYC  turn length limit in cycles (TTT_TURN_TIMEOUT_EN only)
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             new-game request, honoured in IDLE or DONE only
//   game_over         win indication from the core (level)
//   p_valid/p_pos     player move request, p_ready accepts it
//   c_valid/c_pos     computer move request, c_ready accepts it
//   play              one-cycle game-start pulse to the core
//   player_pos        last accepted player cell, held between moves
//   comp_pos          last accepted computer cell, held between moves
//   mv_strobe/mv_who  one-cycle pulse per accepted move, with the mover's side
//   illegal           one-cycle pulse when a handshake carried a bad move
//   timeout           one-cycle pulse when a turn was forfeited
//   board             occupancy map, bit k set means cell k+1 is taken
//   move_cnt          accepted moves, 0..9
//   board_full        move_cnt == 9
// ---------------------------------------------------------------------------
module ttt_move_sequencer #(
  parameter int POS_W       = 4,
  parameter int FIRST_MOVER = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             game_over,
  input  logic             p_valid,
  input  logic [POS_W-1:0] p_pos,
  output logic             p_ready,
  input  logic             c_valid,
  input  logic [POS_W-1:0] c_pos,
  output logic             c_ready,
  output logic             play,
  output logic [POS_W-1:0] player_pos,
  output logic [POS_W-1:0] comp_pos,
  output logic             mv_strobe,
  output logic             mv_who,
  output logic             illegal,
  output logic             timeout,
  output logic [8:0]       board,
  output logic [3:0]       move_cnt,
  output logic             board_full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_P_TURN,
    S_C_TURN,
    S_DONE
  } state_t;

  // Turn state that START hands over to, picked once at elaboration.
  localparam state_t FIRST_TURN = (FIRST_MOVER != 0) ? S_C_TURN : S_P_TURN;

  state_t           state_q, state_d;
  logic [8:0]       board_q, board_d;
  logic [3:0]       move_cnt_q, move_cnt_d;
  logic [POS_W-1:0] player_pos_q, player_pos_d;
  logic [POS_W-1:0] comp_pos_q, comp_pos_d;
  logic             mv_strobe_q, mv_strobe_d;
  logic             mv_who_q, mv_who_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic             in_turn;
  logic             c_turn;
  logic             turn_hs;
  logic [POS_W-1:0] turn_pos;
  logic [8:0]       cell_sel;
  logic             move_legal;
  logic             tmo_expire;

  // Each channel is ready only on its own turn. game_over drops ready in the
  // same cycle, so a move that arrives together with a win is never taken.
  always_comb begin
    p_ready = (state_q == S_P_TURN) && !game_over;
    c_ready = (state_q == S_C_TURN) && !game_over;
  end

  // Select the channel whose turn it is. A handshake is possible only on
  // that channel, because the other channel's ready is low.
  always_comb begin
    in_turn  = (state_q == S_P_TURN) || (state_q == S_C_TURN);
    c_turn   = (state_q == S_C_TURN);
    turn_hs  = (p_valid && p_ready) || (c_valid && c_ready);
    turn_pos = c_turn ? c_pos : p_pos;
  end

  // Decode the requested cell one-hot. Out-of-range positions (0, 10 and
  // above) produce no select bit. That one check covers both the range test
  // and the occupancy test, and it never indexes the board out of bounds.
  always_comb begin
    cell_sel = '0;
    for (int k = 0; k < 9; k++) begin
      cell_sel[k] = (turn_pos == POS_W'(k + 1));
    end
    move_legal = (|cell_sel) && !(|(cell_sel & board_q));
  end

`ifdef TTT_TURN_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count cycles spent in the current turn. Any state change restarts the
  // count. Illegal attempts do not change the state, so they do not restart
  // it. The count never passes TIMEOUT_CYC-1, because expiry always moves
  // the state on.
  always_comb begin
    tmo_cnt_d = '0;
    if (in_turn && (state_d == state_q)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_expire = in_turn && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  // No turn limit. The expression is 0 for every meaningful TIMEOUT_CYC.
  assign tmo_expire = (TIMEOUT_CYC < 0);
`endif

  // Next-state and datapath update. Pulse outputs default to 0, so each
  // event raises its pulse for exactly one cycle. Board and positions hold
  // unless a legal move or a new game changes them.
  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    move_cnt_d   = move_cnt_q;
    player_pos_d = player_pos_q;
    comp_pos_d   = comp_pos_q;
    mv_strobe_d  = 1'b0;
    mv_who_d     = 1'b0;
    illegal_d    = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_START;
          board_d      = '0;
          move_cnt_d   = '0;
          player_pos_d = '0;
          comp_pos_d   = '0;
        end
      end

      S_START: begin
        state_d = FIRST_TURN;
      end

      S_P_TURN, S_C_TURN: begin
        if (game_over) begin
          // A win outranks both a pending move and an expiring turn.
          state_d = S_DONE;
        end else if (turn_hs && move_legal) begin
          board_d     = board_q | cell_sel;
          mv_strobe_d = 1'b1;
          mv_who_d    = c_turn;
          if (move_cnt_q != 4'd9) begin
            move_cnt_d = move_cnt_q + 4'd1;
          end
          if (c_turn) begin
            comp_pos_d = turn_pos;
          end else begin
            player_pos_d = turn_pos;
          end
          if (move_cnt_q == 4'd8) begin
            state_d = S_DONE;
          end else begin
            state_d = c_turn ? S_P_TURN : S_C_TURN;
          end
        end else begin
          // A rejected move and an expiring turn can fall in the same cycle.
          // In that case both pulses fire.
          illegal_d = turn_hs;
          if (tmo_expire) begin
            timeout_d = 1'b1;
            state_d   = c_turn ? S_P_TURN : S_C_TURN;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared by reset in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      board_q      <= '0;
      move_cnt_q   <= '0;
      player_pos_q <= '0;
      comp_pos_q   <= '0;
      mv_strobe_q  <= 1'b0;
      mv_who_q     <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      move_cnt_q   <= move_cnt_d;
      player_pos_q <= player_pos_d;
      comp_pos_q   <= comp_pos_d;
      mv_strobe_q  <= mv_strobe_d;
      mv_who_q     <= mv_who_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
    end
  end

  // play is a decode of START: that state lasts exactly one cycle.
  always_comb begin
    play       = (state_q == S_START);
    player_pos = player_pos_q;
    comp_pos   = comp_pos_q;
    mv_strobe  = mv_strobe_q;
    mv_who     = mv_who_q;
    illegal    = illegal_q;
    timeout    = timeout_q;
    board      = board_q;
    move_cnt   = move_cnt_q;
    board_full = (move_cnt_q == 4'd9);
  end

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for ttt_move_sequencer.
//
// Stimulus runs directed game scripts first, then random traffic. A
// reference model keeps the game as a list of nine cells and a phase
// number. For every cycle that should raise a pulse, the model pushes the
// expected pulse contents into a queue. A monitor at the falling edge pops
// that queue whenever the DUT raises play, mv_strobe, illegal or timeout.
// Levels (ready, board, counters, positions) are compared against the model
// once per cycle.
// ---------------------------------------------------------------------------
module tb_ttt_move_sequencer;

  localparam int POS_W       = 4;
  localparam int FIRST_MOVER = 0;
  localparam int TIMEOUT_CYC = 16;
`ifdef TTT_TURN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_START = 1;
  localparam int PH_P     = 2;
  localparam int PH_C     = 3;
  localparam int PH_DONE  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             game_over = 1'b0;
  logic             p_valid = 1'b0;
  logic [POS_W-1:0] p_pos = '0;
  logic             p_ready;
  logic             c_valid = 1'b0;
  logic [POS_W-1:0] c_pos = '0;
  logic             c_ready;
  logic             play;
  logic [POS_W-1:0] player_pos;
  logic [POS_W-1:0] comp_pos;
  logic             mv_strobe;
  logic             mv_who;
  logic             illegal;
  logic             timeout;
  logic [8:0]       board;
  logic [3:0]       move_cnt;
  logic             board_full;

  ttt_move_sequencer #(
    .POS_W      (POS_W),
    .FIRST_MOVER(FIRST_MOVER),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .game_over (game_over),
    .p_valid   (p_valid),
    .p_pos     (p_pos),
    .p_ready   (p_ready),
    .c_valid   (c_valid),
    .c_pos     (c_pos),
    .c_ready   (c_ready),
    .play      (play),
    .player_pos(player_pos),
    .comp_pos  (comp_pos),
    .mv_strobe (mv_strobe),
    .mv_who    (mv_who),
    .illegal   (illegal),
    .timeout   (timeout),
    .board     (board),
    .move_cnt  (move_cnt),
    .board_full(board_full)
  );

  always #5 clk = ~clk;

  // Count of rising edges, used to tag when each expected pulse is due.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int         cyc;
    bit         play;
    bit         strobe;
    bit         who;
    bit         ill;
    bit         tmo;
    logic [8:0] board;
    int         cnt;
    int         ppos;
    int         cpos;
  } ev_t;

  ev_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_phase = PH_IDLE;
  bit m_cell[9];
  int m_cnt  = 0;
  int m_ppos = 0;
  int m_cpos = 0;
  int m_wait = 0;

  function automatic logic [8:0] modelBoard();
    logic [8:0] b;
    for (int k = 0; k < 9; k++) b[k] = m_cell[k];
    return b;
  endfunction

  function automatic void modelClear();
    for (int k = 0; k < 9; k++) m_cell[k] = 1'b0;
    m_cnt  = 0;
    m_ppos = 0;
    m_cpos = 0;
  endfunction

  function automatic void compareVal(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic modelStep(input bit r, input bit s, input bit g,
                           input bit pv, input logic [3:0] pp,
                           input bit cv, input logic [3:0] cp);
    int  old_phase;
    bit  any;
    bit  ctrn;
    bit  v;
    int  pos;
    bit  expire;
    ev_t e;
    old_phase = m_phase;
    any       = 1'b0;
    e         = '{cyc: cyc + 1, play: 0, strobe: 0, who: 0, ill: 0, tmo: 0,
                  board: '0, cnt: 0, ppos: 0, cpos: 0};
    if (r) begin
      m_phase = PH_IDLE;
      modelClear();
      m_wait = 0;
      return;
    end
    case (m_phase)
      PH_IDLE, PH_DONE: begin
        if (s) begin
          m_phase = PH_START;
          modelClear();
          e.play = 1'b1;
          any    = 1'b1;
        end
      end
      PH_START: m_phase = (FIRST_MOVER != 0) ? PH_C : PH_P;
      default: begin
        ctrn   = (m_phase == PH_C);
        v      = ctrn ? cv : pv;
        pos    = ctrn ? int'(cp) : int'(pp);
        expire = TMO_EN && (m_wait == TIMEOUT_CYC - 1);
        if (g) begin
          m_phase = PH_DONE;
        end else if (v && pos >= 1 && pos <= 9 && !m_cell[pos - 1]) begin
          m_cell[pos - 1] = 1'b1;
          m_cnt++;
          if (ctrn) m_cpos = pos;
          else      m_ppos = pos;
          e.strobe = 1'b1;
          e.who    = ctrn;
          any      = 1'b1;
          m_phase  = (m_cnt == 9) ? PH_DONE : (ctrn ? PH_P : PH_C);
        end else begin
          if (v) begin
            e.ill = 1'b1;
            any   = 1'b1;
          end
          if (expire) begin
            e.tmo   = 1'b1;
            any     = 1'b1;
            m_phase = ctrn ? PH_P : PH_C;
          end
        end
      end
    endcase
    if (m_phase != old_phase)                   m_wait = 0;
    else if (m_phase == PH_P || m_phase == PH_C) m_wait++;
    else                                         m_wait = 0;
    if (any) begin
      e.board = modelBoard();
      e.cnt   = m_cnt;
      e.ppos  = m_ppos;
      e.cpos  = m_cpos;
      exp_q.push_back(e);
    end
  endtask

  // Level outputs against the model. Call this after the inputs for the
  // coming edge have settled, because ready depends on game_over.
  task automatic checkOutput();
    compareVal("p_ready", p_ready, (m_phase == PH_P) && !game_over);
    compareVal("c_ready", c_ready, (m_phase == PH_C) && !game_over);
    compareVal("board", board, modelBoard());
    compareVal("move_cnt", move_cnt, m_cnt);
    compareVal("board_full", board_full, m_cnt == 9);
    compareVal("player_pos", player_pos, m_ppos);
    compareVal("comp_pos", comp_pos, m_cpos);
  endtask

  // Drive one cycle of inputs shortly after a rising edge, check the levels,
  // step the model, then wait for the next edge.
  task automatic applyStimulus(input bit r, input bit s, input bit g,
                               input bit pv, input logic [3:0] pp,
                               input bit cv, input logic [3:0] cp);
    rst       = r;
    start     = s;
    game_over = g;
    p_valid   = pv;
    p_pos     = pp;
    c_valid   = cv;
    c_pos     = cp;
    #1;
    checkOutput();
    modelStep(r, s, g, pv, pp, cv, cp);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 4'd0, 0, 4'd0);
  endtask

  // The opposite channel also presents a request. It must be ignored.
  task automatic playerMove(input logic [3:0] pos);
    applyStimulus(0, 0, 0, 1, pos, 1, 4'd2);
  endtask

  task automatic compMove(input logic [3:0] pos);
    applyStimulus(0, 0, 0, 1, 4'd3, 1, pos);
  endtask

  // Pulse monitor. Each pulse cycle must match the oldest expected entry,
  // and any entry whose cycle has passed unseen counts as missed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL missed_pulse: got no pulse, expected one at cycle %0d (now %0d)",
               exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (play === 1'b1 || mv_strobe === 1'b1 || illegal === 1'b1 || timeout === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_pulse: got play=%b strobe=%b illegal=%b timeout=%b, expected none (cycle %0d)",
                 play, mv_strobe, illegal, timeout, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        compareVal("pulse_play", play, e.play);
        compareVal("pulse_mv_strobe", mv_strobe, e.strobe);
        compareVal("pulse_illegal", illegal, e.ill);
        compareVal("pulse_timeout", timeout, e.tmo);
        if (e.strobe) compareVal("pulse_mv_who", mv_who, e.who);
        compareVal("pulse_board", board, e.board);
        compareVal("pulse_move_cnt", move_cnt, e.cnt);
        compareVal("pulse_player_pos", player_pos, e.ppos);
        compareVal("pulse_comp_pos", comp_pos, e.cpos);
      end
    end
  end

  // Random game traffic. The valid probability changes in bursts so that
  // long quiet turns (timeouts) and busy turns both occur.
  task automatic randomTraffic(input int n);
    int          vprob;
    bit          r, s, g, pv, cv;
    logic [3:0]  pp, cp;
    vprob = 40;
    for (int i = 0; i < n; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       vprob = 4;
          1:       vprob = 40;
          default: vprob = 85;
        endcase
      end
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 14) == 0);
      g  = ($urandom_range(0, 59) == 0);
      pv = ($urandom_range(0, 99) < vprob);
      cv = ($urandom_range(0, 99) < vprob);
      pp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
      cp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
      applyStimulus(r, s, g, pv, pp, cv, cp);
    end
  endtask

  initial begin
    // Hold reset for two edges, then check that every output is cleared.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_phase = PH_IDLE;
    modelClear();
    m_wait = 0;
    checkOutput();
    compareVal("reset_play", play, 0);
    compareVal("reset_mv_strobe", mv_strobe, 0);
    compareVal("reset_mv_who", mv_who, 0);
    compareVal("reset_illegal", illegal, 0);
    compareVal("reset_timeout", timeout, 0);

    // First game: the opening move, three rejected computer moves, then
    // the full alternating sequence to a full board.
    applyStimulus(0, 1, 0, 0, 4'd0, 0, 4'd0);
    idleCycles(1);
    playerMove(4'd5);
    compMove(4'd5);
    compMove(4'd0);
    compMove(4'd10);
    compMove(4'd1);
    playerMove(4'd7);
    compMove(4'd3);
    playerMove(4'd2);
    compMove(4'd8);
    playerMove(4'd9);
    compMove(4'd4);
    playerMove(4'd6);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 1, 4'(i), 1, 4'(i + 4));
    idleCycles(1);

    // Second game: a win reported together with a player move, then a
    // reset while in DONE.
    applyStimulus(0, 1, 0, 0, 4'd0, 0, 4'd0);
    idleCycles(1);
    playerMove(4'd1);
    compMove(4'd2);
    applyStimulus(0, 0, 1, 1, 4'd6, 0, 4'd0);
    applyStimulus(0, 0, 0, 1, 4'd6, 0, 4'd0);
    idleCycles(2);
    applyStimulus(1, 0, 0, 0, 4'd0, 0, 4'd0);
    compareVal("midreset_board", board, 0);
    compareVal("midreset_move_cnt", move_cnt, 0);
    compareVal("midreset_player_pos", player_pos, 0);

    // Clean game after reset, then a quiet player turn long enough to
    // expire when the turn limit is built in.
    applyStimulus(0, 1, 0, 0, 4'd0, 0, 4'd0);
    idleCycles(1);
    playerMove(4'd3);
    compMove(4'd7);
    idleCycles(TIMEOUT_CYC + 4);
    applyStimulus(0, 0, 0, 1, 4'd3, 1, 4'd3);
    applyStimulus(0, 0, 0, 1, 4'd4, 1, 4'd4);
    idleCycles(2);

    randomTraffic(3000);
    idleCycles(3);

    while (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL leftover_pulse: got no pulse, expected one at cycle %0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
